// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] FUNC_MULTU = 2'b00;
  localparam logic [1:0] FUNC_MULT  = 2'b01;
  localparam logic [1:0] FUNC_DIVU  = 2'b10;
  localparam logic [1:0] FUNC_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit: operands/control in, HI/LO and status out.
interface muldiv_if #(
  parameter int unsigned DATA_W = muldiv_pkg::DATA_W_DEF
);

  logic              i_step;
  logic              i_start;
  logic [1:0]        i_func;
  logic [DATA_W-1:0] i_rs_reg;
  logic [DATA_W-1:0] i_rt_reg;
  logic              i_mthi;
  logic              i_mtlo;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_step, i_start, i_func, i_rs_reg, i_rt_reg, i_mthi, i_mtlo,
    input  o_hi, o_lo, o_busy, o_done
  );

  modport slave (
    input  i_step, i_start, i_func, i_rs_reg, i_rt_reg, i_mthi, i_mtlo,
    output o_hi, o_lo, o_busy, o_done
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of a HI/LO pair, either as two
// independent words or (wide = 1) as one double-width value controlled by neg_lo.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] hi_in,
  input  logic [W-1:0] lo_in,
  input  logic         neg_hi,
  input  logic         neg_lo,
  input  logic         wide,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);

  logic [2*W-1:0] joined_c;
  logic [2*W-1:0] joined_neg_c;

  always_comb begin
    joined_c     = {hi_in, lo_in};
    joined_neg_c = -joined_c;
    hi_out       = neg_hi ? -hi_in : hi_in;
    lo_out       = neg_lo ? -lo_in : lo_in;
    if (wide) begin
      {hi_out, lo_out} = neg_lo ? joined_neg_c : joined_c;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, one radix-2 step per i_step.
// Optional build macro MULDIV_ZERO_SKIP_EN finishes zero-operand operations on the start step.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 5
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int unsigned W2 = 2 * DATA_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_hi_q, neg_hi_d;
  logic               neg_lo_q, neg_lo_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div_c, is_signed_c, rs_neg_c, rt_neg_c, rt_zero_c, last_c;
  logic [DATA_W-1:0]  mag_a_c, mag_b_c, fix_hi_c, fix_lo_c;
  logic [DATA_W-1:0]  addend_c, div_diff_c, div_rem_c;
  logic [DATA_W:0]    mul_sum_c, div_shl_c;
  logic               div_ge_c;
  logic [W2-1:0]      iter_c;

  // Decode of the incoming request
  always_comb begin
    is_div_c    = (bus.i_func == FUNC_DIVU) || (bus.i_func == FUNC_DIV);
    is_signed_c = (bus.i_func == FUNC_MULT) || (bus.i_func == FUNC_DIV);
    rs_neg_c    = is_signed_c & bus.i_rs_reg[DATA_W-1];
    rt_neg_c    = is_signed_c & bus.i_rt_reg[DATA_W-1];
    rt_zero_c   = (bus.i_rt_reg == '0);
    last_c      = (cnt_q == CNT_W'(DATA_W - 1));
  end

  muldiv_signfix #(.W(DATA_W)) u_pre (
    .hi_in  (bus.i_rs_reg),
    .lo_in  (bus.i_rt_reg),
    .neg_hi (rs_neg_c),
    .neg_lo (rt_neg_c),
    .wide   (1'b0),
    .hi_out (mag_a_c),
    .lo_out (mag_b_c)
  );

  // One iteration: shift-add (multiplier in acc low half) or restoring shift-subtract
  always_comb begin
    addend_c   = acc_q[0] ? opb_q : '0;
    mul_sum_c  = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, addend_c};
    div_shl_c  = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
    div_ge_c   = (div_shl_c >= {1'b0, opb_q});
    div_diff_c = div_shl_c[DATA_W-1:0] - opb_q;
    div_rem_c  = div_ge_c ? div_diff_c : div_shl_c[DATA_W-1:0];
    iter_c     = is_div_q ? {div_rem_c, acc_q[DATA_W-2:0], div_ge_c}
                          : {mul_sum_c, acc_q[DATA_W-1:1]};
  end

  muldiv_signfix #(.W(DATA_W)) u_post (
    .hi_in  (iter_c[W2-1:DATA_W]),
    .lo_in  (iter_c[DATA_W-1:0]),
    .neg_hi (neg_hi_q),
    .neg_lo (neg_lo_q),
    .wide   (~is_div_q),
    .hi_out (fix_hi_c),
    .lo_out (fix_lo_c)
  );

  // Next-state and datapath update; nothing moves unless i_step is high
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (bus.i_step) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          if (bus.i_start) begin
            // Divide-by-zero keeps the quotient unsigned so LO stays all ones
            state_d  = ST_BUSY;
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = is_div_c;
            opb_d    = is_div_c ? mag_b_c : mag_a_c;
            acc_d    = {DATA_W'(0), (is_div_c ? mag_a_c : mag_b_c)};
            neg_hi_d = rs_neg_c;
            neg_lo_d = (rs_neg_c ^ rt_neg_c) & ~(is_div_c & rt_zero_c);
`ifdef MULDIV_ZERO_SKIP_EN
            if ((bus.i_rs_reg == '0) || rt_zero_c) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              hi_d    = (is_div_c && rt_zero_c) ? bus.i_rs_reg : '0;
              lo_d    = (is_div_c && rt_zero_c) ? '1 : '0;
            end
`endif
          end else begin
            if (bus.i_mthi) hi_d = bus.i_rs_reg;
            if (bus.i_mtlo) lo_d = bus.i_rs_reg;
          end
        end
        ST_BUSY: begin
          acc_d = iter_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            hi_d    = fix_hi_c;
            lo_d    = fix_lo_c;
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected HI/LO/latency, a monitor checks on o_done.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst;

  muldiv_if #(.DATA_W(32)) bus ();

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 32;
`endif

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_cnt = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst && bus.i_step) step_cnt <= step_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rising o_done retires the oldest expected result
  always @(negedge clk) begin
    if (rst && bus.o_done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, ".hi"}, bus.o_hi, e.hi);
        check({e.nm, ".lo"}, bus.o_lo, e.lo);
        check({e.nm, ".lat"}, 32'(step_cnt - e.start), 32'(e.lat));
        check({e.nm, ".busy"}, 32'(bus.o_busy), 32'd0);
      end
    end
    done_prev = bus.o_done;
  end

  // mt_mode: 0 none, 1 MTHI/MTLO together with start, 2 MTHI/MTLO held during BUSY
  task automatic do_op(input string nm, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input bit toggle, input int mt_mode);
    exp_t e;
    bit   got = 1'b0;
    if (lat == 0) begin
      @(negedge clk);
      bus.i_step  = 1'b1;
      bus.i_start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus.i_step   = 1'b1;
    bus.i_start  = 1'b1;
    bus.i_func   = f;
    bus.i_rs_reg = a;
    bus.i_rt_reg = b;
    bus.i_mthi   = (mt_mode == 1);
    bus.i_mtlo   = (mt_mode == 1);
    @(posedge clk);
    #1;
    e.nm = nm; e.hi = eh; e.lo = el; e.start = step_cnt; e.lat = lat;
    sb.push_back(e);
    check({nm, ".busy_start"}, 32'(bus.o_busy), 32'(lat != 0));
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_step  = toggle ? 1'b0 : 1'b1;
    bus.i_mthi  = (mt_mode == 2);
    bus.i_mtlo  = (mt_mode == 2);
    if (mt_mode == 2) bus.i_rs_reg = 32'h0000_1234;
    for (int k = 0; k < 200 && !got; k++) begin
      if (bus.o_done) got = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        if (toggle) bus.i_step = ~bus.i_step;
      end
    end
    if (!got) begin
      check({nm, ".timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    bus.i_step = 1'b0;
    bus.i_mthi = 1'b0;
    bus.i_mtlo = 1'b0;
  endtask

  task automatic mt_write(input bit h, input bit l, input logic [31:0] v);
    @(negedge clk);
    bus.i_step   = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_mthi   = h;
    bus.i_mtlo   = l;
    bus.i_rs_reg = v;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.i_step = 1'b0;
    bus.i_mthi = 1'b0;
    bus.i_mtlo = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.i_step = 1'b0; bus.i_start = 1'b0; bus.i_func = 2'b00;
    bus.i_rs_reg = '0; bus.i_rt_reg = '0; bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.hi",   bus.o_hi, 32'h0);
    check("reset.lo",   bus.o_lo, 32'h0);
    check("reset.busy", 32'(bus.o_busy), 32'd0);
    check("reset.done", 32'(bus.o_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("multu_ff_x2",   2'b00, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, 32,   1'b0, 0);
    do_op("mult_m3_x5",    2'b01, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 32,   1'b0, 0);
    do_op("div_m7_2",      2'b11, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32,   1'b0, 0);
    do_op("divu_7_0",      2'b10, 32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF, ZLAT, 1'b0, 0);
    do_op("div_min_m1",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 32,   1'b0, 0);
    do_op("mult_min_m1",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 32,   1'b0, 0);
    do_op("div_7_m2",      2'b11, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 32,   1'b0, 0);
    do_op("div_m7_0",      2'b11, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, ZLAT, 1'b0, 0);
    do_op("multu_0_x5",    2'b00, 32'h0,         32'h5,         32'h0,         32'h0,         ZLAT, 1'b0, 0);
    do_op("multu_wide",    2'b00, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 32,   1'b0, 0);
    do_op("mult_m1_m1",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         32,   1'b0, 0);
    do_op("divu_100_7_tg", 2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        32,   1'b1, 0);
    do_op("multu_mt_busy", 2'b00, 32'd6,         32'd7,         32'd0,         32'd42,        32,   1'b0, 2);
    do_op("divu_mt_start", 2'b10, 32'd9,         32'd4,         32'd1,         32'd2,         32,   1'b0, 1);

    mt_write(1'b1, 1'b0, 32'h0000_1234);
    check("mthi.hi", bus.o_hi, 32'h0000_1234);
    check("mthi.lo", bus.o_lo, 32'h2);
    mt_write(1'b0, 1'b1, 32'h0000_ABCD);
    check("mtlo.hi", bus.o_hi, 32'h0000_1234);
    check("mtlo.lo", bus.o_lo, 32'h0000_ABCD);
    mt_write(1'b1, 1'b1, 32'h55);
    check("mtboth.hi", bus.o_hi, 32'h55);
    check("mtboth.lo", bus.o_lo, 32'h55);

    // Abort a multiply with reset after 10 iterations
    @(negedge clk);
    bus.i_step = 1'b1; bus.i_start = 1'b1; bus.i_func = 2'b00;
    bus.i_rs_reg = 32'd3; bus.i_rt_reg = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.busy", 32'(bus.o_busy), 32'd0);
    check("abort.hi",   bus.o_hi, 32'h0);
    check("abort.lo",   bus.o_lo, 32'h0);
    check("abort.done", 32'(bus.o_done), 32'd0);
    bus.i_step = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_op("multu_after_rst", 2'b00, 32'd3, 32'd3, 32'd0, 32'd9, 32, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
